// File: rtl/hack_cpu_mc_if.sv
// Hack CPU bus: instruction fetch handshake plus data-memory request/response signals.
// The master modport is the CPU side, the slave modport is the memory/ROM side.
interface hack_cpu_mc_if #(
  parameter int WIDTH = 16,
  parameter int AW    = WIDTH - 1
);
  logic [WIDTH-1:0] instruction;
  logic             instr_valid;
  logic [WIDTH-1:0] inM;
  logic             mem_ready;
  logic             fetch;
  logic             readM;
  logic             writeM;
  logic [WIDTH-1:0] outM;
  logic [AW-1:0]    addressM;
  logic [AW-1:0]    pc;
  logic             halted;

  modport master (
    input  instruction, instr_valid, inM, mem_ready,
    output fetch, readM, writeM, outM, addressM, pc, halted
  );

  modport slave (
    output instruction, instr_valid, inM, mem_ready,
    input  fetch, readM, writeM, outM, addressM, pc, halted
  );
endinterface

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: FETCH -> EXEC -> (MEM) -> FETCH, stopping in HALT on a taken self-jump.
// Memory accesses stall in MEM until mem_ready; the instruction commits on that edge.
module hack_cpu_mc #(
  parameter int WIDTH = 16,
  parameter int AW    = WIDTH - 1
) (
  input  logic          clk,
  input  logic          reset,
  hack_cpu_mc_if.master bus
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic             fetch_q, fetch_d;
  logic             readm_q, readm_d;
  logic             writem_q, writem_d;
  logic             halted_q, halted_d;

  logic [WIDTH-1:0] alu_x, alu_y, alu_f, alu_out;
  logic             is_c, bit_a, zr, ng, jump, commit;

  // Hack ALU; y selects inM only for a=1, which only commits when mem_ready is high
  always_comb begin
    is_c  = ir_q[WIDTH-1];
    bit_a = ir_q[12];
    alu_x = ir_q[11] ? '0 : d_q;
    if (ir_q[10]) alu_x = ~alu_x;
    alu_y = bit_a ? bus.inM : a_q;
    if (ir_q[9]) alu_y = '0;
    if (ir_q[8]) alu_y = ~alu_y;
    alu_f   = ir_q[7] ? (alu_x + alu_y) : (alu_x & alu_y);
    alu_out = ir_q[6] ? ~alu_f : alu_f;
    zr      = (alu_out == '0);
    ng      = alu_out[WIDTH-1];
    jump    = (ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~ng & ~zr);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    d_d      = d_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    fetch_d  = fetch_q;
    readm_d  = readm_q;
    writem_d = writem_q;
    halted_d = halted_q;
    commit   = 1'b0;

    case (state_q)
      FETCH: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instruction;
          state_d = EXEC;
          fetch_d = 1'b0;
        end
      end
      EXEC: begin
        if (!is_c) begin
          a_d     = {1'b0, ir_q[WIDTH-2:0]};
          pc_d    = pc_q + AW'(1);
          state_d = FETCH;
          fetch_d = 1'b1;
        end else if (bit_a || ir_q[3]) begin
          state_d  = MEM;
          readm_d  = bit_a;
          writem_d = ir_q[3];
        end else begin
          commit = 1'b1;
        end
      end
      MEM: begin
        if (bus.mem_ready) begin
          commit   = 1'b1;
          readm_d  = 1'b0;
          writem_d = 1'b0;
        end
      end
      default: ;
    endcase

    // Jump target and self-jump test both use A as it was before this commit
    if (commit) begin
      if (ir_q[5]) a_d = alu_out;
      if (ir_q[4]) d_d = alu_out;
      if (jump && (a_q[AW-1:0] == pc_q)) begin
        state_d  = HALT;
        halted_d = 1'b1;
        fetch_d  = 1'b0;
      end else begin
        pc_d    = jump ? a_q[AW-1:0] : (pc_q + AW'(1));
        state_d = FETCH;
        fetch_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      a_q      <= '0;
      d_q      <= '0;
      ir_q     <= '0;
      pc_q     <= '0;
      fetch_q  <= 1'b1;
      readm_q  <= 1'b0;
      writem_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      d_q      <= d_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      fetch_q  <= fetch_d;
      readm_q  <= readm_d;
      writem_q <= writem_d;
      halted_q <= halted_d;
    end
  end

  assign bus.fetch    = fetch_q;
  assign bus.readM    = readm_q;
  assign bus.writeM   = writem_q;
  assign bus.halted   = halted_q;
  assign bus.outM     = alu_out;
  assign bus.addressM = a_q[AW-1:0];
  assign bus.pc       = pc_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Randomised bench for hack_cpu_mc: an instruction-level Hack model predicts fetch pcs,
// memory transactions and halts; a negedge monitor pops and compares them as they appear.
module tb_hack_cpu_mc;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [14:0] addr;
    logic [15:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hack_cpu_mc_if #(.WIDTH(16), .AW(15)) bus ();
  hack_cpu_mc_if #(.WIDTH(24), .AW(16)) wbus ();

  hack_cpu_mc #(.WIDTH(16), .AW(15)) dut (.clk(clk), .reset(reset), .bus(bus.master));
  hack_cpu_mc #(.WIDTH(24), .AW(16)) dut_w (.clk(clk), .reset(reset), .bus(wbus.master));

  logic [15:0] rom     [0:32767];
  logic [15:0] dut_ram [0:32767];
  logic [15:0] ref_ram [0:32767];
  logic [5:0]  comp_tbl [18];

  txn_t        exp_q[$];
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  bit          m_halt;
  bit          rand_drive = 1'b1;
  bit          allow_fetch = 1'b1;
  int          n_checks = 0, n_fail = 0, n_exec = 0, n_halts = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Standard Hack comp mnemonics expressed as plain arithmetic on D and y (A or M)
  function automatic logic [15:0] hack_op(input logic [5:0] c, input logic [15:0] dv, input logic [15:0] yv);
    case (c)
      6'h2A: return 16'd0;
      6'h3F: return 16'd1;
      6'h3A: return 16'hFFFF;
      6'h0C: return dv;
      6'h30: return yv;
      6'h0D: return ~dv;
      6'h31: return ~yv;
      6'h0F: return 16'(0 - dv);
      6'h33: return 16'(0 - yv);
      6'h1F: return 16'(dv + 1);
      6'h37: return 16'(yv + 1);
      6'h0E: return 16'(dv - 1);
      6'h32: return 16'(yv - 1);
      6'h02: return 16'(dv + yv);
      6'h13: return 16'(dv - yv);
      6'h07: return 16'(yv - dv);
      6'h00: return dv & yv;
      6'h15: return dv | yv;
      default: return 16'hxxxx;
    endcase
  endfunction

  function automatic logic [15:0] gen_instr();
    logic [2:0] jmp;
    if ($urandom_range(0, 9) < 4)
      return ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 31)) : 16'($urandom_range(0, 32767));
    jmp = ($urandom_range(0, 9) < 3) ? 3'($urandom_range(1, 7)) : 3'b000;
    return {3'b111, 1'($urandom_range(0, 1)), comp_tbl[$urandom_range(0, 17)], 3'($urandom_range(0, 7)), jmp};
  endfunction

  task automatic model_reset();
    m_a = '0; m_d = '0; m_pc = '0; m_halt = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [15:0] ins);
    logic [15:0] y, res, old_a;
    bit take;
    txn_t t;
    if (!ins[15]) begin
      m_a  = {1'b0, ins[14:0]};
      m_pc = 15'(m_pc + 1);
      return;
    end
    old_a = m_a;
    y     = ins[12] ? ref_ram[old_a[14:0]] : old_a;
    res   = hack_op(ins[11:6], m_d, y);
    if (ins[12] || ins[3]) begin
      t = '{wr: ins[3], rd: ins[12], addr: old_a[14:0], data: res};
      exp_q.push_back(t);
      if (ins[3]) ref_ram[old_a[14:0]] = res;
    end
    take = (ins[2] && $signed(res) < 0) || (ins[1] && res == 0) || (ins[0] && $signed(res) > 0);
    if (ins[5]) m_a = res;
    if (ins[4]) m_d = res;
    if (take && old_a[14:0] == m_pc) m_halt = 1'b1;
    else m_pc = take ? old_a[14:0] : 15'(m_pc + 1);
  endtask

  // Random responder: new inputs shortly after each rising edge
  always @(posedge clk) begin
    #1;
    if (rand_drive) begin
      bus.instr_valid = allow_fetch && ($urandom_range(0, 3) != 0);
      bus.instruction = rom[bus.pc];
      bus.mem_ready   = ($urandom_range(0, 2) == 0);
      bus.inM         = dut_ram[bus.addressM];
    end
  end

  // Monitor: fetch handshakes step the model, completed accesses pop the scoreboard
  always @(negedge clk) begin
    txn_t t;
    if (reset) begin
      if (bus.fetch && bus.instr_valid) begin
        if (m_halt) checkOutput("fetch_after_halt", 1'b1, 1'b0);
        else begin
          checkOutput("fetch_pc", bus.pc, m_pc);
          model_step(bus.instruction);
          n_exec++;
        end
      end
      if ((bus.readM || bus.writeM) && bus.mem_ready) begin
        if (exp_q.size() == 0) checkOutput("mem_txn_unexpected", {bus.writeM, bus.readM, bus.addressM}, 0);
        else begin
          t = exp_q.pop_front();
          checkOutput("mem_txn", {bus.writeM, bus.readM, bus.addressM, bus.writeM ? bus.outM : 16'h0},
                      {t.wr, t.rd, t.addr, t.wr ? t.data : 16'h0});
        end
        if (bus.writeM) dut_ram[bus.addressM] = bus.outM;
      end
    end
  end

  task automatic handle_halt();
    bit seen = 1'b0, noisy = 1'b0;
    for (int c = 0; c < 150 && !seen; c++) begin
      @(negedge clk);
      seen = bus.halted;
    end
    checkOutput("halt_reached", seen, 1'b1);
    checkOutput("halt_pc", bus.pc, m_pc);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.fetch || bus.readM || bus.writeM || !bus.halted) noisy = 1'b1;
    end
    checkOutput("halt_quiet", noisy, 1'b0);
    checkOutput("halt_queue_empty", exp_q.size(), 0);
    reset = 1'b0;
    #1;
    checkOutput("reset_clears_halt", {bus.halted, bus.pc, bus.addressM}, {1'b0, 15'd0, 15'd0});
    model_reset();
    n_halts++;
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_fetch", {bus.fetch, bus.pc}, {1'b1, 15'd0});
  endtask

  function automatic logic [23:0] wide_rom(input logic [15:0] a);
    case (a)
      16'h0000: return 24'h00FFFF;
      16'h0001: return 24'hFFEA87;
      16'hFFFF: return 24'hFFEE88;
      default:  return 24'h000000;
    endcase
  endfunction

  initial begin
    bit done = 1'b0, hit = 1'b0, w_seen = 1'b0, w_top = 1'b0, w_wrap = 1'b0;
    logic [23:0] w_out = '0;
    logic [15:0] w_addr = '0;

    comp_tbl = '{6'h2A, 6'h3F, 6'h3A, 6'h0C, 6'h30, 6'h0D, 6'h31, 6'h0F, 6'h33,
                 6'h1F, 6'h37, 6'h0E, 6'h32, 6'h02, 6'h13, 6'h07, 6'h00, 6'h15};
    for (int i = 0; i < 32768; i++) begin
      rom[i]     = gen_instr();
      dut_ram[i] = 16'($urandom);
      ref_ram[i] = dut_ram[i];
    end
    bus.instr_valid  = 1'b0; bus.instruction  = '0; bus.mem_ready  = 1'b0; bus.inM  = '0;
    wbus.instr_valid = 1'b0; wbus.instruction = '0; wbus.mem_ready = 1'b0; wbus.inM = '0;
    model_reset();

    repeat (3) @(negedge clk);
    checkOutput("reset_state", {bus.readM, bus.writeM, bus.halted, bus.pc, bus.addressM}, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    checkOutput("first_fetch", {bus.fetch, bus.pc}, {1'b1, 15'd0});

    for (int cyc = 0; cyc < 40000 && !done; cyc++) begin
      @(negedge clk);
      if (m_halt) handle_halt();
      if (n_exec >= 600) done = 1'b1;
    end
    checkOutput("random_progress", done, 1'b1);

    allow_fetch = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (m_halt || bus.fetch) break;
    end
    if (m_halt) handle_halt();
    else checkOutput("drain_queue_empty", exp_q.size(), 0);
    $display("[TB] random phase: %0d instructions, %0d halts", n_exec, n_halts);

    // Reset while a write is stalled in MEM must cancel it
    rand_drive = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus.instr_valid = 1'b0;
    bus.mem_ready   = 1'b0;
    model_reset();
    rom[0] = 16'h0005;
    rom[1] = 16'hE308;
    dut_ram[5] = 16'h1234;
    ref_ram[5] = 16'h1234;
    bus.instruction = rom[0];
    @(posedge clk);
    #2 reset = 1'b1;
    bus.instr_valid = 1'b1;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(posedge clk);
      #1 bus.instruction = rom[bus.pc];
      @(negedge clk);
      hit = bus.writeM;
    end
    checkOutput("mem_write_pending", {hit, bus.addressM, bus.outM, bus.pc}, {1'b1, 15'd5, 16'd0, 15'd1});
    reset = 1'b0;
    #1;
    checkOutput("reset_drops_write", {bus.writeM, bus.readM, bus.pc, bus.addressM}, 0);
    model_reset();
    bus.instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("no_write_recorded", dut_ram[5], 16'h1234);

    // 24-bit core: jump to 0xFFFF, store -1 there, then wrap pc to 0
    @(posedge clk);
    #2 reset = 1'b1;
    wbus.instruction = wide_rom(16'h0000);
    wbus.instr_valid = 1'b1;
    wbus.mem_ready   = 1'b1;
    for (int c = 0; c < 40 && !w_wrap; c++) begin
      @(posedge clk);
      #1 wbus.instruction = wide_rom(wbus.pc);
      @(negedge clk);
      if (wbus.writeM) begin
        w_seen = 1'b1;
        w_out  = wbus.outM;
        w_addr = wbus.addressM;
      end
      if (wbus.pc == 16'hFFFF) w_top = 1'b1;
      if (w_top && wbus.pc == 16'h0000) w_wrap = 1'b1;
    end
    checkOutput("wide_write_seen", w_seen, 1'b1);
    checkOutput("wide_outM", w_out, 24'hFFFFFF);
    checkOutput("wide_ng", w_out[23], 1'b1);
    checkOutput("wide_addressM", w_addr, 16'hFFFF);
    checkOutput("wide_pc_wrap", {w_top, w_wrap}, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
